tour_cmd: RTL

- Issues commands into the command processor's cmd/cmd_rdy/clr_cmd_rdy/send_resp handshake, acting as the initiator for that interface.
- Sources commands from the UART path when no tour is running.
- During a knight's tour, walks the solved move list from the tour logic and expands each one-hot knight move into two move commands: a vertical leg, then a horizontal leg with fanfare.
- Generates the 8-bit response byte returned over UART.

---
 rtl/tour_cmd.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - command initiator: UART pass-through when idle, knight's tour move expansion otherwise
// Optional TOUR_ABORT_EN: a UART opcode-0 command during a tour ends it after the current move.
module tour_cmd #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   typedef enum logic [2:0] {IDLE, VERT, WAIT_VERT, HORZ, WAIT_HORZ} state_t;

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   state_t      state, nxt_state;
   logic [3:0]  dx_mag, dy_mag;
   logic        dx_neg, dy_neg;
   logic [15:0] vert_cmd, horz_cmd;
   logic        last_move;
   logic        abort_pend;
   logic        abort_req;

   // Lowest set bit wins; a zero vector decodes to zero-length legs heading south/west.
   always_comb begin
      dx_mag = 4'd0; dy_mag = 4'd0;
      dx_neg = 1'b1; dy_neg = 1'b1;
      casez (move)
         8'b???????1: begin dx_mag = 4'd1; dx_neg = 1'b0; dy_mag = 4'd2; dy_neg = 1'b0; end
         8'b??????10: begin dx_mag = 4'd1; dx_neg = 1'b1; dy_mag = 4'd2; dy_neg = 1'b0; end
         8'b?????100: begin dx_mag = 4'd2; dx_neg = 1'b1; dy_mag = 4'd1; dy_neg = 1'b0; end
         8'b????1000: begin dx_mag = 4'd2; dx_neg = 1'b1; dy_mag = 4'd1; dy_neg = 1'b1; end
         8'b???10000: begin dx_mag = 4'd1; dx_neg = 1'b1; dy_mag = 4'd2; dy_neg = 1'b1; end
         8'b??100000: begin dx_mag = 4'd1; dx_neg = 1'b0; dy_mag = 4'd2; dy_neg = 1'b1; end
         8'b?1000000: begin dx_mag = 4'd2; dx_neg = 1'b0; dy_mag = 4'd1; dy_neg = 1'b1; end
         8'b10000000: begin dx_mag = 4'd2; dx_neg = 1'b0; dy_mag = 4'd1; dy_neg = 1'b0; end
         default: ;
      endcase
   end

   assign vert_cmd  = {4'h4, (dy_neg ? 8'h7F : 8'h00), dy_mag};
   assign horz_cmd  = {4'h5, (dx_neg ? 8'h3F : 8'hBF), dx_mag};
   assign last_move = (mv_indx == LAST_INDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:      if (start_tour)  nxt_state = VERT;
         VERT:      if (clr_cmd_rdy) nxt_state = WAIT_VERT;
         WAIT_VERT: if (send_resp)   nxt_state = HORZ;
         HORZ:      if (clr_cmd_rdy) nxt_state = WAIT_HORZ;
         WAIT_HORZ: if (send_resp)   nxt_state = (last_move || abort_pend) ? IDLE : VERT;
         default:                    nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mv_indx <= 5'd0;
      else if (state == IDLE && start_tour)
         mv_indx <= 5'd0;
      else if (state == WAIT_HORZ && send_resp && !last_move && !abort_pend)
         mv_indx <= mv_indx + 5'd1;
   end

`ifdef TOUR_ABORT_EN
   // Consume the abort once; the pending flag masks further pulses until the tour ends.
   assign abort_req = (state != IDLE) && cmd_rdy_UART && (cmd_UART[15:12] == 4'h0) && !abort_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  abort_pend <= 1'b0;
      else if (nxt_state == IDLE)  abort_pend <= 1'b0;
      else if (abort_req)          abort_pend <= 1'b1;
   end
`else
   assign abort_req  = 1'b0;
   assign abort_pend = 1'b0;
`endif

   always_comb begin
      cmd              = cmd_UART;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = abort_req;
      resp             = 8'h5A;
      case (state)
         IDLE: begin
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = 8'hA5;
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
         end
         WAIT_VERT: cmd = vert_cmd;
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
         end
         WAIT_HORZ: begin
            cmd = horz_cmd;
            if (last_move || abort_pend) resp = 8'hA5;
         end
         default: ;
      endcase
   end

endmodule
